rv_multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the RV32I core.
- Sequences fetch, decode, execute, memory and writeback around the decoder, ALU, register file and memories.
- Drives the datapath booleans (is_write, alusrc, pcsrc, regwritesrc, is_access_memory, is_write_memory) plus PC/IR write enables.
- Handles memory ready handshakes, memory timeouts and illegal-opcode trapping, and counts retired instructions.

---
 rtl/rv_multicycle_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv_multicycle_ctrl.sv
// Purpose: multi-cycle control FSM for an RV32I core; sequences FETCH, DECODE, EXEC, MEM, WB and TRAP.
// Latency: 3 cycles BRANCH, 4 cycles ALU/JAL/JALR/STORE, 5 cycles LOAD, plus one per memory wait cycle.
// Backpressure: holds in FETCH/MEM until imem_ready/dmem_ready; traps after TIMEOUT_CYCLES unready cycles.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   imem_rdata/ready  - fetched instruction word and its handshake
//   dmem_ready        - data memory handshake
//   br_taken          - branch condition from the ALU, used only in EXEC of a BRANCH
//   imem_req, ir_we, pc_we, is_write, alusrc, pcsrc, regwritesrc,
//   is_access_memory, is_write_memory - datapath control
//   illegal, trap_cause, state, instret - status and debug

module rv_multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        br_taken,
    output logic        imem_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic        is_write,
    output logic        alusrc,
    output logic        pcsrc,
    output logic        regwritesrc,
    output logic        is_access_memory,
    output logic        is_write_memory,
    output logic        illegal,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_IMEM    = 2'd2;
    localparam logic [1:0] CAUSE_DMEM    = 2'd3;

    // Counter value seen during the last tolerated unready cycle.
    localparam logic [9:0] WAIT_LAST = 10'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [6:0]  r_opcode;
    logic [9:0]  r_wait;
    logic [31:0] r_instret;
    logic        r_illegal;
    logic [1:0]  r_cause;

    logic w_is_load;
    logic w_is_store;
    logic w_is_branch;
    logic w_is_jump;
    logic w_uses_imm;
    logic w_legal;
    logic w_wait_expired;
    logic w_unused_rdata;

    assign w_is_load      = (r_opcode == OPC_LOAD);
    assign w_is_store     = (r_opcode == OPC_STORE);
    assign w_is_branch    = (r_opcode == OPC_BRANCH);
    assign w_is_jump      = (r_opcode == OPC_JAL) || (r_opcode == OPC_JALR);
    assign w_uses_imm     = r_opcode inside {OPC_OPIMM, OPC_LOAD, OPC_STORE,
                                             OPC_LUI, OPC_AUIPC, OPC_JALR};
    assign w_legal        = r_opcode inside {OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OPIMM,
                                             OPC_LOAD, OPC_STORE, OPC_BRANCH,
                                             OPC_JAL, OPC_JALR};
    assign w_wait_expired = (r_wait == WAIT_LAST);
    // Only the opcode field is consumed here; the rest of the word feeds the datapath.
    assign w_unused_rdata = ^imem_rdata[31:7];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_opcode  <= 7'd0;
            r_wait    <= 10'd0;
            r_instret <= 32'd0;
            r_illegal <= 1'b0;
            r_cause   <= 2'd0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        r_opcode <= imem_rdata[6:0];
                        r_wait   <= 10'd0;
                        r_state  <= S_DECODE;
                    end else if (w_wait_expired) begin
                        r_illegal <= 1'b1;
                        r_cause   <= CAUSE_IMEM;
                        r_state   <= S_TRAP;
                    end else begin
                        r_wait <= r_wait + 10'd1;
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_illegal <= 1'b1;
                        r_cause   <= CAUSE_ILLEGAL;
                        r_state   <= S_TRAP;
                    end
                end
                S_EXEC: begin
                    if (w_is_load || w_is_store) begin
                        r_wait  <= 10'd0;
                        r_state <= S_MEM;
                    end else if (w_is_branch) begin
                        r_instret <= r_instret + 32'd1;
                        r_wait    <= 10'd0;
                        r_state   <= S_FETCH;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    // A ready in the final tolerated cycle still completes the access.
                    if (dmem_ready) begin
                        r_wait <= 10'd0;
                        if (w_is_store) begin
                            r_instret <= r_instret + 32'd1;
                            r_state   <= S_FETCH;
                        end else begin
                            r_state <= S_WB;
                        end
                    end else if (w_wait_expired) begin
                        r_illegal <= 1'b1;
                        r_cause   <= CAUSE_DMEM;
                        r_state   <= S_TRAP;
                    end else begin
                        r_wait <= r_wait + 10'd1;
                    end
                end
                S_WB: begin
                    r_instret <= r_instret + 32'd1;
                    r_wait    <= 10'd0;
                    r_state   <= S_FETCH;
                end
                S_TRAP: begin
                    r_state <= S_TRAP;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    // Control decode from the registered state and opcode. Strobes are held
    // low while rst is asserted so an aborted instruction never writes state.
    always_comb begin
        imem_req         = 1'b0;
        ir_we            = 1'b0;
        pc_we            = 1'b0;
        is_write         = 1'b0;
        alusrc           = 1'b0;
        pcsrc            = 1'b0;
        regwritesrc      = 1'b0;
        is_access_memory = 1'b0;
        is_write_memory  = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                S_EXEC: begin
                    alusrc = w_uses_imm;
                    if (w_is_branch) begin
                        pc_we = 1'b1;
                        pcsrc = br_taken;
                    end
                end
                S_MEM: begin
                    is_access_memory = 1'b1;
                    is_write_memory  = w_is_store;
                    // PC advances once, when the store completes.
                    pc_we            = w_is_store && dmem_ready;
                end
                S_WB: begin
                    is_write    = 1'b1;
                    pc_we       = 1'b1;
                    pcsrc       = w_is_jump;
                    regwritesrc = !w_is_load;
                end
                default: begin
                end
            endcase
        end
    end

    assign state      = r_state;
    assign illegal    = r_illegal;
    assign trap_cause = r_cause;
    assign instret    = r_instret;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Purpose: self-checking bench for rv_multicycle_ctrl with an expected-state scoreboard.
// Latency: inputs driven on negedge, outputs sampled 1 ns later, away from posedge.
// Backpressure: memory ready patterns are driven per cycle from each test.

module tb_rv_multicycle_ctrl;

    localparam int TMO = 4;
    localparam logic [31:0] W_ADD = 32'h002081B3;
    localparam logic [31:0] W_LW  = 32'h0000A183;
    localparam logic [31:0] W_SW  = 32'h0020A023;
    localparam logic [31:0] W_BEQ = 32'h00208463;
    localparam logic [31:0] W_BAD = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        br_taken = 1'b0;
    logic        imem_req, ir_we, pc_we, is_write, alusrc, pcsrc, regwritesrc;
    logic        is_access_memory, is_write_memory, illegal;
    logic [1:0]  trap_cause;
    logic [2:0]  state;
    logic [31:0] instret;

    int          checks = 0;
    int          errors = 0;
    logic [2:0]  q_state[$];
    logic [2:0]  exp_st;
    logic [31:0] exp_instret;
    logic        saw_write;

    rv_multicycle_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .br_taken(br_taken), .imem_req(imem_req),
        .ir_we(ir_we), .pc_we(pc_we), .is_write(is_write), .alusrc(alusrc),
        .pcsrc(pcsrc), .regwritesrc(regwritesrc), .is_access_memory(is_access_memory),
        .is_write_memory(is_write_memory), .illegal(illegal), .trap_cause(trap_cause),
        .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    // One clock cycle of stimulus; releases rst and records any register-file write.
    task automatic cycle(input logic [31:0] w, input logic ir, input logic dr, input logic bt);
        @(negedge clk);
        rst = 1'b0; imem_rdata = w; imem_ready = ir; dmem_ready = dr; br_taken = bt;
        #1;
        if (is_write === 1'b1) saw_write = 1'b1;
    endtask

    // Holds rst across a posedge and leaves it high; the next cycle() releases it.
    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; br_taken = 1'b0;
        @(negedge clk); #1;
        q_state.delete();
        exp_instret = 32'd0;
        saw_write = 1'b0;
    endtask

    task automatic pop_state(input string tag);
        exp_st = q_state.pop_front();
        checks++;
        if (state !== exp_st) begin
            errors++; $display("FAIL %s state got %0d want %0d", tag, state, exp_st);
        end
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d want 0", state); end
        checks++; if (instret !== 32'd0) begin errors++; $display("FAIL rst_instret got %0d want 0", instret); end
        checks++; if (illegal !== 1'b0 || trap_cause !== 2'd0) begin
            errors++; $display("FAIL rst_trap got %0b/%0d want 0/0", illegal, trap_cause); end
        checks++; if (pc_we !== 1'b0 || is_write !== 1'b0 || is_access_memory !== 1'b0) begin
            errors++; $display("FAIL rst_strobes got %0b%0b%0b want 000", pc_we, is_write, is_access_memory); end
    endtask

    task automatic test_add;
        do_reset();
        q_state.push_back(3'd0); q_state.push_back(3'd1); q_state.push_back(3'd2);
        q_state.push_back(3'd4); q_state.push_back(3'd0);
        exp_instret = exp_instret + 32'd1;
        for (int i = 0; i < 5; i++) begin
            cycle(W_ADD, (i < 4), 1'b1, 1'b0);
            pop_state("add");
            if (i == 0) begin checks++; if (ir_we !== 1'b1) begin errors++; $display("FAIL add_ir_we got %0b want 1", ir_we); end end
            if (i == 2) begin checks++; if (alusrc !== 1'b0) begin errors++; $display("FAIL add_alusrc got %0b want 0", alusrc); end end
            if (i == 3) begin
                checks++;
                if ({is_write, pc_we, regwritesrc, pcsrc} !== 4'b1110) begin
                    errors++; $display("FAIL add_wb got %b want 1110", {is_write, pc_we, regwritesrc, pcsrc}); end
            end
        end
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL add_instret got %0d want %0d", instret, exp_instret); end
    endtask

    task automatic test_lw_wait;
        do_reset();
        q_state.push_back(3'd0); q_state.push_back(3'd1); q_state.push_back(3'd2);
        for (int k = 0; k < 4; k++) q_state.push_back(3'd3);
        q_state.push_back(3'd4); q_state.push_back(3'd0);
        exp_instret = exp_instret + 32'd1;
        for (int i = 0; i < 9; i++) begin
            cycle(W_LW, (i == 0), (i == 6), 1'b0);
            pop_state("lw");
            if (i == 2) begin checks++; if (alusrc !== 1'b1) begin errors++; $display("FAIL lw_alusrc got %0b want 1", alusrc); end end
            if (i >= 3 && i <= 6) begin
                checks++;
                if (is_access_memory !== 1'b1 || is_write_memory !== 1'b0) begin
                    errors++; $display("FAIL lw_mem got %0b%0b want 10", is_access_memory, is_write_memory); end
            end
            if (i == 7) begin
                checks++;
                if (is_write !== 1'b1 || regwritesrc !== 1'b0) begin
                    errors++; $display("FAIL lw_wb got %0b%0b want 10", is_write, regwritesrc); end
            end
        end
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL lw_instret got %0d want %0d", instret, exp_instret); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        q_state.push_back(3'd0); q_state.push_back(3'd1); q_state.push_back(3'd2); q_state.push_back(3'd3);
        q_state.push_back(3'd0); q_state.push_back(3'd1); q_state.push_back(3'd2); q_state.push_back(3'd0);
        exp_instret = exp_instret + 32'd2;
        for (int i = 0; i < 8; i++) begin
            cycle((i < 4) ? W_SW : W_BEQ, (i == 0 || i == 4), 1'b1, 1'b1);
            pop_state("b2b");
            if (i == 2) begin checks++; if (pc_we !== 1'b0 || alusrc !== 1'b1) begin
                errors++; $display("FAIL sw_exec got pc_we=%0b alusrc=%0b want 0/1", pc_we, alusrc); end end
            if (i == 3) begin
                checks++;
                if ({is_access_memory, is_write_memory, pc_we, pcsrc} !== 4'b1110) begin
                    errors++; $display("FAIL sw_mem got %b want 1110", {is_access_memory, is_write_memory, pc_we, pcsrc}); end
            end
            if (i == 6) begin
                checks++;
                if (pc_we !== 1'b1 || pcsrc !== 1'b1) begin
                    errors++; $display("FAIL beq_exec got %0b%0b want 11", pc_we, pcsrc); end
            end
        end
        checks++; if (saw_write !== 1'b0) begin errors++; $display("FAIL b2b_is_write got %0b want 0", saw_write); end
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL b2b_instret got %0d want %0d", instret, exp_instret); end
    endtask

    task automatic test_illegal;
        do_reset();
        q_state.push_back(3'd0); q_state.push_back(3'd1);
        for (int k = 0; k < 21; k++) q_state.push_back(3'd5);
        for (int i = 0; i < 23; i++) begin
            cycle(W_BAD, 1'b1, 1'b1, 1'b0);
            pop_state("illegal");
        end
        checks++; if (illegal !== 1'b1 || trap_cause !== 2'd1) begin
            errors++; $display("FAIL illegal_flag got %0b/%0d want 1/1", illegal, trap_cause); end
        checks++; if (imem_req !== 1'b0 || pc_we !== 1'b0) begin
            errors++; $display("FAIL trap_strobes got %0b%0b want 00", imem_req, pc_we); end
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL illegal_instret got %0d want %0d", instret, exp_instret); end
        do_reset();
        checks++; if (state !== 3'd0 || illegal !== 1'b0) begin
            errors++; $display("FAIL illegal_clear got %0d/%0b want 0/0", state, illegal); end
    endtask

    task automatic test_timeout;
        do_reset();
        for (int k = 0; k < TMO; k++) q_state.push_back(3'd0);
        q_state.push_back(3'd5);
        for (int i = 0; i <= TMO; i++) begin
            cycle(W_ADD, 1'b0, 1'b0, 1'b0);
            pop_state("tmo");
        end
        checks++; if (trap_cause !== 2'd2 || illegal !== 1'b1) begin
            errors++; $display("FAIL tmo_cause got %0d/%0b want 2/1", trap_cause, illegal); end
        do_reset();
        for (int k = 0; k < TMO; k++) q_state.push_back(3'd0);
        q_state.push_back(3'd1);
        for (int i = 0; i <= TMO; i++) begin
            cycle(W_ADD, (i == TMO - 1), 1'b0, 1'b0);
            pop_state("tmo_edge");
            if (i == TMO - 1) begin checks++; if (ir_we !== 1'b1) begin
                errors++; $display("FAIL tmo_edge_ir_we got %0b want 1", ir_we); end end
        end
        checks++; if (illegal !== 1'b0 || trap_cause !== 2'd0) begin
            errors++; $display("FAIL tmo_edge_trap got %0b/%0d want 0/0", illegal, trap_cause); end
    endtask

    task automatic test_rst_mid;
        do_reset();
        q_state.push_back(3'd0); q_state.push_back(3'd1); q_state.push_back(3'd2);
        q_state.push_back(3'd3); q_state.push_back(3'd3);
        for (int i = 0; i < 5; i++) begin
            cycle(W_LW, (i == 0), 1'b0, 1'b0);
            pop_state("rst_mid");
        end
        @(negedge clk);
        rst = 1'b1; dmem_ready = 1'b1;
        #1;
        checks++; if (is_write !== 1'b0 || pc_we !== 1'b0) begin
            errors++; $display("FAIL rst_mid_strobes got %0b%0b want 00", is_write, pc_we); end
        q_state.push_back(3'd0); q_state.push_back(3'd0);
        for (int i = 0; i < 2; i++) begin
            cycle(W_LW, 1'b0, 1'b1, 1'b0);
            pop_state("rst_mid_after");
        end
        checks++; if (instret !== exp_instret) begin errors++; $display("FAIL rst_mid_instret got %0d want %0d", instret, exp_instret); end
        checks++; if (saw_write !== 1'b0) begin errors++; $display("FAIL rst_mid_is_write got %0b want 0", saw_write); end
    endtask

    initial begin
        exp_instret = 32'd0;
        saw_write = 1'b0;
        test_reset();
        test_add();
        test_lw_wait();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
